// File: rtl/iitb_risc_pkg.sv
// Shared encodings and the EX-stage control bundle for the
// ALU flag control path.
package iitb_risc_pkg;

    localparam int ALU_OP_W = 2;

    localparam logic [3:0] OPC_ADI  = 4'b0000;
    localparam logic [3:0] OPC_ADD  = 4'b0001;
    localparam logic [3:0] OPC_NAND = 4'b0010;

    localparam logic [1:0] COND_NONE = 2'b00;
    localparam logic [1:0] COND_Z    = 2'b01;
    localparam logic [1:0] COND_C    = 2'b10;
    localparam logic [1:0] COND_L    = 2'b11;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_NAND = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 2'b10;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                rwe;
        logic                cwe;
        logic                zwe;
        logic                cond_fail;
    } ex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-class decode with carry/zero predication.
// Produces the EX control bundle from ID-stage inputs.
module alu_ctrl_decode
    import iitb_risc_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0]  instr,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                rwe,
    input  logic                eff_c,
    input  logic                eff_z,
    output ex_ctrl_t            ctrl
);

    logic [3:0] opc;
    logic [1:0] cond;
    logic       is_alu;
    logic       is_nand;
    logic       need_c;
    logic       need_z;
    logic       unused_bits;

    assign opc         = instr[INSTR_W-1 -: 4];
    assign cond        = instr[1:0];
    assign unused_bits = ^instr[INSTR_W-5:2];

    always_comb begin
        is_alu  = 1'b0;
        is_nand = 1'b0;
        need_c  = 1'b0;
        need_z  = 1'b0;
        unique case (1'b1)
            (opc == OPC_ADI): begin
                is_alu = 1'b1;
            end
            (opc == OPC_ADD): begin
                is_alu = 1'b1;
                need_c = (cond == COND_C);
                need_z = (cond == COND_Z);
            end
            (opc == OPC_NAND) && (cond != COND_L): begin
                is_alu  = 1'b1;
                is_nand = 1'b1;
                need_c  = (cond == COND_C);
                need_z  = (cond == COND_Z);
            end
            default: begin
                is_alu = 1'b0;
            end
        endcase
    end

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = alu_op;
        ctrl.rwe    = rwe;
        if (is_alu) begin
            ctrl.alu_op = is_nand ? ALU_NAND : ALU_ADD;
            // A non-writing ALU instruction skips predication entirely
            if (!rwe) begin
                ctrl.rwe = 1'b0;
            end else if ((need_c && !eff_c) || (need_z && !eff_z)) begin
                ctrl.alu_op    = ALU_PASS;
                ctrl.rwe       = 1'b0;
                ctrl.cond_fail = 1'b1;
            end else begin
                ctrl.rwe = 1'b1;
                ctrl.cwe = !is_nand;
                ctrl.zwe = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_flag_ctrl.sv
// Registered ALU control at ID/EX: flag forwarding, EX register,
// architectural carry/zero flags and a saturating fail counter.
module alu_flag_ctrl
    import iitb_risc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_rwe,
    input  logic               stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_carry,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_rwe,
    output logic               ex_cwe,
    output logic               ex_zwe,
    output logic               ex_cond_fail,
    output logic               carry_flag,
    output logic               zero_flag,
    output logic [CNT_W-1:0]   fail_count
);

    ex_ctrl_t         dec;
    ex_ctrl_t         ex_q;
    logic             ex_valid_q;
    logic             carry_q;
    logic             zero_q;
    logic [CNT_W-1:0] fail_q;
    logic             res_zero;
    logic             eff_c;
    logic             eff_z;
    logic             commit;

    assign res_zero = (alu_result == '0);
    assign eff_c    = (ex_valid_q && ex_q.cwe) ? alu_carry : carry_q;
    assign eff_z    = (ex_valid_q && ex_q.zwe) ? res_zero : zero_q;
    // Flush overrides stall, so the EX instruction retires when flushed
    assign commit   = ex_valid_q && (flush || !stall);

    alu_ctrl_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .instr  (id_instr),
        .alu_op (id_alu_op),
        .rwe    (id_rwe),
        .eff_c  (eff_c),
        .eff_z  (eff_z),
        .ctrl   (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (!stall) begin
            ex_valid_q <= id_valid;
            if (id_valid) begin
                ex_q <= dec;
            end else begin
                ex_q        <= '0;
                ex_q.alu_op <= dec.alu_op;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            fail_q  <= '0;
        end else if (commit) begin
            if (ex_q.cwe) begin
                carry_q <= alu_carry;
            end
            if (ex_q.zwe) begin
                zero_q <= res_zero;
            end
            if (ex_q.cond_fail && (fail_q != '1)) begin
                fail_q <= fail_q + 1'b1;
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_rwe       = ex_q.rwe;
    assign ex_cwe       = ex_q.cwe;
    assign ex_zwe       = ex_q.zwe;
    assign ex_cond_fail = ex_q.cond_fail;
    assign carry_flag   = carry_q;
    assign zero_flag    = zero_q;
    assign fail_count   = fail_q;

endmodule

// File: tb/tb_alu_flag_ctrl.sv
// Directed scoreboard bench for alu_flag_ctrl with a 4-bit
// fail counter so saturation is reachable.
module tb_alu_flag_ctrl;

    localparam int CW = 4;

    // {valid, op[1:0], rwe, cwe, zwe, cond_fail}
    localparam logic [6:0] E_BUB  = 7'b0000000;
    localparam logic [6:0] E_ADD  = 7'b1001110;
    localparam logic [6:0] E_PRED = 7'b1100001;
    localparam logic [6:0] E_NDZ  = 7'b1011010;
    localparam logic [6:0] E_NOWR = 7'b1000000;
    localparam logic [6:0] E_DFLT = 7'b1101000;

    localparam logic [15:0] I_ADD = 16'h1000;
    localparam logic [15:0] I_ADC = 16'h1002;
    localparam logic [15:0] I_NDZ = 16'h2001;
    localparam logic [15:0] I_NDL = 16'h2003;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [15:0]   id_instr;
    logic [1:0]    id_alu_op;
    logic          id_rwe;
    logic          stall;
    logic          flush;
    logic [15:0]   alu_result;
    logic          alu_carry;
    logic          ex_valid;
    logic [1:0]    ex_alu_op;
    logic          ex_rwe;
    logic          ex_cwe;
    logic          ex_zwe;
    logic          ex_cond_fail;
    logic          carry_flag;
    logic          zero_flag;
    logic [CW-1:0] fail_count;

    int checks = 0;
    int errors = 0;
    logic [6:0] sb[$];

    alu_flag_ctrl #(
        .DATA_W  (16),
        .INSTR_W (16),
        .ALUOP_W (2),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_alu_op    (id_alu_op),
        .id_rwe       (id_rwe),
        .stall        (stall),
        .flush        (flush),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .ex_valid     (ex_valid),
        .ex_alu_op    (ex_alu_op),
        .ex_rwe       (ex_rwe),
        .ex_cwe       (ex_cwe),
        .ex_zwe       (ex_zwe),
        .ex_cond_fail (ex_cond_fail),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .fail_count   (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic id(input logic v, input logic [15:0] ins,
                      input logic [1:0] op, input logic we,
                      input logic [6:0] exp);
        id_valid  = v;
        id_instr  = ins;
        id_alu_op = op;
        id_rwe    = we;
        sb.push_back(exp);
    endtask

    task automatic alu(input logic [15:0] res, input logic c);
        alu_result = res;
        alu_carry  = c;
    endtask

    task automatic tick(input string tag);
        logic [6:0] e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(tag, {25'd0, ex_valid, ex_alu_op, ex_rwe, ex_cwe,
                      ex_zwe, ex_cond_fail}, {25'd0, e});
        end
    endtask

    task automatic flags(input string tag, input logic c, input logic z,
                         input int n);
        chk({tag, "_c"}, {31'd0, carry_flag}, {31'd0, c});
        chk({tag, "_z"}, {31'd0, zero_flag}, {31'd0, z});
        chk({tag, "_n"}, {28'd0, fail_count}, n);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        id_valid = 1'b0;
        id_instr = '0;
        id_alu_op = '0;
        id_rwe = 1'b0;
        alu(16'h0000, 1'b0);
        #12;
        chk("rst_ex", {25'd0, ex_valid, ex_alu_op, ex_rwe, ex_cwe,
                       ex_zwe, ex_cond_fail}, 32'd0);
        flags("rst", 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        id(1'b1, I_ADD, 2'b11, 1'b1, E_ADD);
        tick("add");
        flags("add", 1'b0, 1'b0, 0);
        id(1'b0, 16'h0000, 2'b00, 1'b0, E_BUB);
        alu(16'h0000, 1'b1);
        tick("add_commit");
        flags("add_commit", 1'b1, 1'b1, 0);

        id(1'b1, I_ADD, 2'b00, 1'b1, E_ADD);
        tick("add2");
        id(1'b0, 16'h0000, 2'b00, 1'b0, E_BUB);
        alu(16'h0005, 1'b0);
        tick("add2_commit");
        flags("clr", 1'b0, 1'b0, 0);

        id(1'b1, I_ADC, 2'b00, 1'b1, E_PRED);
        tick("adc_pred");
        id(1'b0, 16'h0000, 2'b00, 1'b0, E_BUB);
        tick("adc_pred_commit");
        flags("adc_pred", 1'b0, 1'b0, 1);

        id(1'b1, I_ADD, 2'b00, 1'b1, E_ADD);
        tick("fwd_add");
        id(1'b1, I_ADC, 2'b00, 1'b1, E_ADD);
        alu(16'h0003, 1'b1);
        chk("fwd_pre_c", {31'd0, carry_flag}, 32'd0);
        tick("fwd_adc");
        flags("fwd", 1'b1, 1'b0, 1);
        id(1'b0, 16'h0000, 2'b00, 1'b0, E_BUB);
        alu(16'h0000, 1'b0);
        tick("fwd_commit");
        flags("fwd_commit", 1'b0, 1'b1, 1);

        id(1'b1, I_NDZ, 2'b00, 1'b1, E_NDZ);
        tick("ndz");
        stall = 1'b1;
        alu(16'h0007, 1'b1);
        for (int i = 0; i < 3; i++) begin
            id(1'b1, I_ADD, 2'b00, 1'b1, E_NDZ);
            tick("ndz_stall");
            flags("ndz_stall", 1'b0, 1'b1, 1);
        end
        stall = 1'b0;
        id(1'b0, 16'h0000, 2'b00, 1'b0, E_BUB);
        alu(16'h0008, 1'b1);
        tick("ndz_commit");
        flags("ndz_commit", 1'b0, 1'b0, 1);

        id(1'b1, I_ADD, 2'b00, 1'b1, E_ADD);
        tick("fl_add");
        stall = 1'b1;
        flush = 1'b1;
        id(1'b1, I_ADD, 2'b00, 1'b1, E_BUB);
        alu(16'h0000, 1'b1);
        tick("flush");
        flags("flush", 1'b1, 1'b1, 1);
        stall = 1'b0;
        flush = 1'b0;

        id(1'b1, I_ADD, 2'b00, 1'b1, E_ADD);
        tick("sat_add");
        id(1'b0, 16'h0000, 2'b00, 1'b0, E_BUB);
        alu(16'h0001, 1'b0);
        tick("sat_clr");
        flags("sat_clr", 1'b0, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            id(1'b1, I_ADC, 2'b00, 1'b1, E_PRED);
            tick("sat_adc");
            chk("sat_cnt", {28'd0, fail_count}, (i + 1 > 15) ? 15 : i + 1);
        end

        id(1'b1, I_ADC, 2'b00, 1'b0, E_NOWR);
        tick("no_rwe");
        id(1'b1, I_NDL, 2'b10, 1'b1, E_DFLT);
        tick("default");
        id(1'b0, I_ADD, 2'b00, 1'b1, E_BUB);
        tick("inval");
        flags("tail", 1'b0, 1'b0, 15);

        id(1'b1, I_ADD, 2'b00, 1'b1, E_ADD);
        tick("pre_rst_add");
        id(1'b1, I_ADD, 2'b00, 1'b1, E_ADD);
        alu(16'h0000, 1'b1);
        tick("pre_rst_add2");
        flags("pre_rst", 1'b1, 1'b1, 15);
        stall = 1'b1;
        flush = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ex", {25'd0, ex_valid, ex_alu_op, ex_rwe, ex_cwe,
                           ex_zwe, ex_cond_fail}, 32'd0);
        flags("mid_rst", 1'b0, 1'b0, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        id(1'b1, I_ADD, 2'b00, 1'b1, E_ADD);
        tick("post_rst");
        flags("post_rst", 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
